// File: rtl/step_sequencer.sv
// Eight-step, four-instrument drum sequencer. A phase accumulator produces the eighth-note
// tempo, and patterns are re-latched only at bar boundaries. Gate pulses can be retriggered.
module step_sequencer #(
  parameter int CLK_HZ      = 50000000,
  parameter int GATE_CYCLES = 2500000,
  parameter int BPM_MIN     = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] bpm,
  input  logic [7:0] ins1,
  input  logic [7:0] ins2,
  input  logic [7:0] ins3,
  input  logic [7:0] ins4,
  output logic       running,
  output logic [2:0] step,
  output logic       step_tick,
  output logic       bar_done,
  output logic [3:0] trig
);

  // One minute of clk cycles. Each step takes LIMIT / (2*bpm) cycles.
  localparam logic [32:0] LIMIT     = 33'(64'(CLK_HZ) * 64'd60);
  localparam logic [31:0] GATE_LOAD = 32'(GATE_CYCLES);
  localparam logic [7:0]  BPM_FLOOR = 8'(BPM_MIN);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  state_t          r_state, w_state_next;
  logic [31:0]     r_acc, w_acc_next;
  logic [31:0]     r_gate, w_gate_next;
  logic [3:0][7:0] r_pat, w_pat_next;
  logic [2:0]      r_step, w_step_next;
  logic            r_running, r_tick, r_bar;
  logic            w_tick_next, w_bar_next;
  logic [3:0]      r_trig, w_trig_next;
  logic [7:0]      w_bpm_eff;
  logic [32:0]     w_sum;
  logic [3:0][7:0] w_ins;

  // Element i holds the pattern for instrument i+1.
  assign w_ins     = {ins4, ins3, ins2, ins1};
  assign w_bpm_eff = (bpm < BPM_FLOOR) ? BPM_FLOOR : bpm;
  assign w_sum     = {1'b0, r_acc} + {24'd0, w_bpm_eff, 1'b0};

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_step_next  = r_step;
    w_pat_next   = r_pat;
    w_tick_next  = 1'b0;
    w_bar_next   = 1'b0;
    w_gate_next  = (r_gate != 32'd0) ? r_gate - 32'd1 : 32'd0;
    w_trig_next  = 4'b0000;

    if (stop) begin
      w_state_next = IDLE;
      w_acc_next   = 32'd0;
      w_step_next  = 3'd0;
      w_gate_next  = 32'd0;
    end else if (start) begin
      w_state_next = PLAY;
      w_acc_next   = 32'd0;
      w_step_next  = 3'd0;
      w_tick_next  = 1'b1;
      w_gate_next  = GATE_LOAD;
      w_pat_next   = w_ins;
    end else if (r_state == PLAY) begin
      if (w_sum >= LIMIT) begin
        w_acc_next  = 32'(w_sum - LIMIT);
        w_step_next = r_step + 3'd1;
        w_tick_next = 1'b1;
        w_gate_next = GATE_LOAD;
        // Pattern edits take effect only when the bar wraps.
        if (r_step == 3'd7) begin
          w_bar_next = 1'b1;
          w_pat_next = w_ins;
        end
      end else begin
        w_acc_next = w_sum[31:0];
      end
    end

    for (int i = 0; i < 4; i++) begin
      w_trig_next[i] = (w_state_next == PLAY) && (w_gate_next != 32'd0) && w_pat_next[i][w_step_next];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_acc     <= 32'd0;
      r_gate    <= 32'd0;
      r_pat     <= '0;
      r_step    <= 3'd0;
      r_running <= 1'b0;
      r_tick    <= 1'b0;
      r_bar     <= 1'b0;
      r_trig    <= 4'b0000;
    end else begin
      r_state   <= w_state_next;
      r_acc     <= w_acc_next;
      r_gate    <= w_gate_next;
      r_pat     <= w_pat_next;
      r_step    <= w_step_next;
      r_running <= (w_state_next == PLAY);
      r_tick    <= w_tick_next;
      r_bar     <= w_bar_next;
      r_trig    <= w_trig_next;
    end
  end

  assign running   = r_running;
  assign step      = r_step;
  assign step_tick = r_tick;
  assign bar_done  = r_bar;
  assign trig      = r_trig;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer. Two instances (gate 10 and gate 100) are
// compared every cycle against a tick/age reference model, plus a vector table and corner sequences.
module tb_step_sequencer;

  localparam int     CLK_HZ = 120;
  localparam int     G_A    = 10;
  localparam int     G_B    = 100;
  localparam longint LIMIT  = 60 * CLK_HZ;
  localparam int     AGE_CAP = 1 << 20;

  logic       clk = 1'b0;
  logic       reset, start, stop;
  logic [7:0] bpm, ins1, ins2, ins3, ins4;
  logic       run_a, tick_a, bar_a, run_b, tick_b, bar_b;
  logic [2:0] step_a, step_b;
  logic [3:0] trig_a, trig_b;

  always #5 clk = ~clk;

  step_sequencer #(.CLK_HZ(CLK_HZ), .GATE_CYCLES(G_A), .BPM_MIN(30)) dut_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .bpm(bpm),
    .ins1(ins1), .ins2(ins2), .ins3(ins3), .ins4(ins4),
    .running(run_a), .step(step_a), .step_tick(tick_a), .bar_done(bar_a), .trig(trig_a)
  );

  step_sequencer #(.CLK_HZ(CLK_HZ), .GATE_CYCLES(G_B), .BPM_MIN(30)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .bpm(bpm),
    .ins1(ins1), .ins2(ins2), .ins3(ins3), .ins4(ins4),
    .running(run_b), .step(step_b), .step_tick(tick_b), .bar_done(bar_b), .trig(trig_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model. Tempo is an integer phase in units of 1/LIMIT minute.
  // The gate is tracked as the number of cycles since the last step entry.
  bit         m_run, m_tick, m_bar;
  int         m_step, m_age;
  longint     m_phase;
  logic [7:0] m_pat [4];

  function automatic logic [3:0] m_trig(input int g);
    logic [3:0] t;
    t = 4'b0000;
    for (int i = 0; i < 4; i++) t[i] = m_run && (m_age < g) && m_pat[i][m_step];
    return t;
  endfunction

  task automatic model_update();
    int b;
    m_tick = 1'b0;
    m_bar  = 1'b0;
    if (!reset) begin
      m_run = 1'b0; m_step = 0; m_phase = 0; m_age = AGE_CAP;
      for (int i = 0; i < 4; i++) m_pat[i] = 8'h00;
    end else if (stop) begin
      m_run = 1'b0; m_step = 0; m_phase = 0;
    end else if (start) begin
      m_run = 1'b1; m_step = 0; m_phase = 0; m_tick = 1'b1; m_age = 0;
      m_pat[0] = ins1; m_pat[1] = ins2; m_pat[2] = ins3; m_pat[3] = ins4;
    end else if (m_run) begin
      b = (bpm < 30) ? 30 : int'(bpm);
      m_phase += 2 * b;
      if (m_phase >= LIMIT) begin
        m_phase -= LIMIT;
        m_tick = 1'b1;
        m_age  = 0;
        if (m_step == 7) begin
          m_bar = 1'b1;
          m_pat[0] = ins1; m_pat[1] = ins2; m_pat[2] = ins3; m_pat[3] = ins4;
        end
        m_step = (m_step + 1) % 8;
      end else if (m_age < AGE_CAP) begin
        m_age++;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // One clock: advance the model on the inputs the DUTs will sample, then compare just after the edge.
  task automatic cycle();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    check("model_a", {22'd0, run_a, step_a, tick_a, bar_a, trig_a},
          {22'd0, m_run, 3'(m_step), m_tick, m_bar, m_trig(G_A)});
    check("model_b", {22'd0, run_b, step_b, tick_b, bar_b, trig_b},
          {22'd0, m_run, 3'(m_step), m_tick, m_bar, m_trig(G_B)});
  endtask

  task automatic wait_tick(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      cycle();
      if (tick_a) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic wait_step(input logic [2:0] s, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      cycle();
      if (step_a == s) begin
        n = i;
        return;
      end
    end
  endtask

  typedef struct {
    logic       rst;
    logic       st;
    logic [7:0] i1;
    logic       run;
    logic [2:0] stp;
    logic       tk;
    logic       br;
    logic [3:0] tg;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int n, ticks, bar_at, hi, lo, pre;
    bit seen;
    reset = 1'b0; start = 1'b0; stop = 1'b0; bpm = 8'd60;
    ins1 = 8'h00; ins2 = 8'h00; ins3 = 8'h00; ins4 = 8'h00;
    m_run = 1'b0; m_tick = 1'b0; m_bar = 1'b0; m_step = 0; m_age = AGE_CAP; m_phase = 0;
    for (int i = 0; i < 4; i++) m_pat[i] = 8'h00;

    // Reset with start held, then a start pulse. The table shows the gate falling 10 cycles later.
    for (int k = 0; k < 14; k++) begin
      vecs[k].i1 = 8'h01;
      if (k < 3) begin
        vecs[k] = '{rst: 1'b0, st: 1'b1, i1: 8'h01, run: 1'b0, stp: 3'd0, tk: 1'b0, br: 1'b0, tg: 4'b0000};
      end else if (k == 3) begin
        vecs[k] = '{rst: 1'b1, st: 1'b1, i1: 8'h01, run: 1'b1, stp: 3'd0, tk: 1'b1, br: 1'b0, tg: 4'b0001};
      end else if (k < 13) begin
        vecs[k] = '{rst: 1'b1, st: 1'b0, i1: 8'h01, run: 1'b1, stp: 3'd0, tk: 1'b0, br: 1'b0, tg: 4'b0001};
      end else begin
        vecs[k] = '{rst: 1'b1, st: 1'b0, i1: 8'h01, run: 1'b1, stp: 3'd0, tk: 1'b0, br: 1'b0, tg: 4'b0000};
      end
    end
    for (int k = 0; k < 14; k++) begin
      reset = vecs[k].rst; start = vecs[k].st; ins1 = vecs[k].i1;
      cycle();
      check("vec_run",  {31'd0, run_a},  {31'd0, vecs[k].run});
      check("vec_step", {29'd0, step_a}, {29'd0, vecs[k].stp});
      check("vec_tick", {31'd0, tick_a}, {31'd0, vecs[k].tk});
      check("vec_bar",  {31'd0, bar_a},  {31'd0, vecs[k].br});
      check("vec_trig", {28'd0, trig_a}, {28'd0, vecs[k].tg});
      $display("vec %0d rst=%0b start=%0b -> run=%0b step=%0d tick=%0b trig=%b",
               k, vecs[k].rst, vecs[k].st, run_a, step_a, tick_a, trig_a);
    end
    start = 1'b0;

    // One full bar at bpm 60 with all patterns set.
    ins1 = 8'hFF; ins2 = 8'hFF; ins3 = 8'hFF; ins4 = 8'hFF; bpm = 8'd60;
    start = 1'b1; cycle(); start = 1'b0;
    check("bar_start_tick", {31'd0, tick_a}, 32'd1);
    ticks = 0; bar_at = -1; hi = 0;
    for (int i = 1; i <= 480; i++) begin
      cycle();
      if (tick_a) ticks++;
      if (bar_a && bar_at < 0) bar_at = i;
      if (trig_a[0]) hi++;
    end
    check("bar_ticks", ticks, 8);
    check("bar_done_at", bar_at, 480);
    check("bar_wrap_step", {29'd0, step_a}, 32'd0);
    check("bar_gate_cycles", hi, 80);
    $display("seq bar: ticks=%0d bar_at=%0d gate_hi=%0d", ticks, bar_at, hi);

    // bpm 0 clamps to 30. A change to 120 mid-step keeps the accumulated phase.
    bpm = 8'd0; start = 1'b1; cycle(); start = 1'b0;
    wait_tick(130, n);
    check("clamp_period", n, 120);
    for (int i = 0; i < 50; i++) cycle();
    bpm = 8'd120;
    wait_tick(40, n);
    check("bpm_change_first", n, 18);
    wait_tick(40, n);
    check("bpm_change_period", n, 30);
    $display("seq tempo: after change period=%0d", n);

    // An ins3 edit mid-bar is ignored until the wrap.
    bpm = 8'd60; ins1 = 8'h01; ins3 = 8'h00;
    start = 1'b1; cycle(); start = 1'b0;
    wait_step(3'd2, 200, n);
    check("edit_reach_step2", {31'd0, (n > 0)}, 32'd1);
    ins3 = 8'hAA;
    pre = 0; seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      cycle();
      if (trig_a[2]) pre++;
      if (bar_a) seen = 1'b1;
    end
    check("edit_wrap_seen", {31'd0, seen}, 32'd1);
    check("edit_pre_wrap", pre, 0);
    hi = 0;
    for (int i = 1; i <= 480; i++) begin
      cycle();
      if (trig_a[2]) hi++;
    end
    check("edit_post_wrap", hi, 40);
    $display("seq edit: pre=%0d post=%0d", pre, hi);

    // Simultaneous start and stop: stop wins.
    start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
    check("ss_running", {31'd0, run_a}, 32'd0);
    check("ss_step", {29'd0, step_a}, 32'd0);
    check("ss_tick", {31'd0, tick_a}, 32'd0);
    check("ss_trig", {28'd0, trig_a}, 32'd0);
    ins1 = 8'hFF;
    start = 1'b1; cycle(); start = 1'b0;
    wait_step(3'd5, 400, n);
    check("rs_reach_step5", {31'd0, (n > 0)}, 32'd1);
    start = 1'b1; cycle(); start = 1'b0;
    check("rs_step", {29'd0, step_a}, 32'd0);
    check("rs_tick", {31'd0, tick_a}, 32'd1);
    check("rs_bar", {31'd0, bar_a}, 32'd0);
    check("rs_running", {31'd0, run_a}, 32'd1);
    $display("seq restart: step=%0d tick=%0b bar=%0b", step_a, tick_a, bar_a);

    // A long gate holds trig across consecutive hit steps.
    ins4 = 8'hFF; bpm = 8'd60;
    start = 1'b1; cycle(); start = 1'b0;
    lo = (trig_b[3] == 1'b0) ? 1 : 0;
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (!trig_b[3]) lo++;
    end
    check("hold_trig_low_cycles", lo, 0);
    stop = 1'b1; cycle(); stop = 1'b0;
    check("hold_stop_trig", {28'd0, trig_b}, 32'd0);
    check("hold_stop_running", {31'd0, run_b}, 32'd0);
    check("hold_stop_tick", {31'd0, tick_b}, 32'd0);
    $display("seq hold: low_cycles=%0d", lo);

    // Random traffic, checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 499) != 0);
      start = ($urandom_range(0, 59) == 0);
      stop  = ($urandom_range(0, 119) == 0);
      if ($urandom_range(0, 49) == 0) bpm = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) begin
        ins1 = 8'($urandom); ins2 = 8'($urandom); ins3 = 8'($urandom); ins4 = 8'($urandom);
      end
      cycle();
    end
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    $display("seq random: 3000 cycles");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
